neuron_lif_integrator: RTL
==========================

# neuron_lif_integrator

- Leaky integrate-and-fire stage directly downstream of the 8-bit Sklansky adder.
- Consumes one 8-bit adder `sum` per accepted transfer as input current and integrates it into a saturating 8-bit membrane potential that leaks every enabled cycle.
- When the membrane reaches a programmable threshold, emits a one-cycle spike, clears the membrane and enters a refractory period that blocks further input.
- Feeds the spike output and spike counter to the neuron's output logic.

## Interface
Parameters:
- `LEAK_SHIFT`, default 3: leak amount is `v >> LEAK_SHIFT`. Legal range 1..7.
- `REFRACT_CYCLES`, default 4: number of enabled cycles spent in REFRACTORY after a fire. Legal range 1..15.

Ports:
- `clk`  input  1: single clock, rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `ena`  input  1: clock enable. While low, all state holds.
- `in_valid`  input  1: `in_sum` is valid.
- `in_sum`  input  8: adder sum, unsigned current.
- `in_ready`  output  1: stage accepts input. Combinational: `ena && state==INTEGRATE`.
- `threshold`  input  8: fire level, unsigned. A value of 0 disables firing.
- `spike`  output  1: registered one-cycle fire pulse.
- `membrane`  output  8: registered membrane potential `v`.
- `spike_count`  output  8: registered count of spikes, wraps modulo 256.

## Operation
- States: INTEGRATE, REFRACTORY. Reset and idle state is INTEGRATE.
- Reset values: `v=0`, `spike=0`, `spike_count=0`, refractory counter `rc=0`, state INTEGRATE.
- Leak applies on every `ena` cycle in INTEGRATE:
  - `leak = v >> LEAK_SHIFT`.
  - If that result is 0 and `v != 0`, then `leak = 1`, so the membrane always decays to 0.
  - `lv = v - leak`.
- Integrate:
  - Transfer condition: `in_valid && in_ready`.
  - On a transfer, `t = lv + in_sum`, computed at 9 bits; otherwise `t = lv`.
  - `vn = (t > 255) ? 255 : t` (saturating).
- Fire check, on INTEGRATE cycles with `ena=1`:
  - Fire when `threshold != 0 && vn >= threshold`.
  - On fire: `v <= 0`, `spike <= 1`, `spike_count <= spike_count + 1` (wrapping), `rc <= REFRACT_CYCLES`, state goes to REFRACTORY.
  - Otherwise: `v <= vn`, `spike <= 0`.
- REFRACTORY, on cycles with `ena=1`:
  - `in_ready=0`, so no transfers occur; `v` is held at 0; no leak; `spike <= 0`.
  - `rc <= rc - 1`.
  - When `rc == 1`, state goes to INTEGRATE on that edge.
- `ena=0`:
  - `v`, `rc`, state and `spike_count` hold.
  - `spike <= 0`, so the pulse is never stretched.
  - `in_ready=0`.
- Threshold is sampled combinationally every cycle. A change takes effect on the next edge.

## Timing
- Input accepted at edge k:
  - `membrane` reflects it after edge k.
  - If it fires, `spike=1` from edge k to edge k+1.
- Fire at edge k: `in_ready` is low for exactly `REFRACT_CYCLES` enabled cycles, then high again. The first new transfer can occur at edge k+`REFRACT_CYCLES`+1.
- Upstream must hold `in_sum` stable while `in_valid=1 && in_ready=0`. `in_valid` may drop without a transfer.
- Saturation and fire on the same edge: the fire wins, and `v` becomes 0.
- `spike_count` at 255 plus a fire: wraps to 0.
- `rst_n` low mid-refractory or mid-spike: all outputs take reset values immediately, without waiting for `clk`.

## Test plan
- Integrate and fire (`LEAK_SHIFT=3`, `threshold=200`, `ena=1`):
  - Stimulus: three back-to-back transfers of `in_sum=100`.
  - Required: `membrane` goes 100, then 188. The third transfer saturates (165+100 → 255), which fires: `spike` is high for one cycle, `membrane=0`, `spike_count=1`.
- Refractory (same setup, `REFRACT_CYCLES=4`):
  - Stimulus: hold `in_valid=1` after the fire.
  - Required: `in_ready=0` for exactly 4 cycles with no transfer; the next value is accepted on the 5th edge.
- Leak decay:
  - Stimulus: `v=100`, no input.
  - Required: `membrane` goes 88, 77, 68, ... and reaches exactly 0. Once `v < 8`, it decrements by 1 per cycle.
- Threshold 0:
  - Stimulus: repeated `in_sum=255`.
  - Required: `membrane` saturates at 255 (net 255 per step after leak); `spike` never asserts; `spike_count` stays 0.
- Enable gating:
  - Stimulus: drop `ena` for 3 cycles mid-integration, then again mid-refractory.
  - Required: `membrane` and `rc` hold; `in_ready=0`; `spike=0`; integration and the refractory countdown resume exactly where they stopped.
- Async reset and counter wrap:
  - Stimulus: assert `rst_n=0` between clock edges during REFRACTORY.
  - Required: `membrane`, `spike` and `spike_count` are 0 and `in_ready` is high once `rst_n` is released.
  - Separately: 256 fires return `spike_count` to 0.

Source files
------------

// File: rtl/neuron_lif_integrator.sv
// Leaky integrate-and-fire stage fed by the 8-bit adder sum.
// The membrane leaks on every enabled cycle while integrating, saturates at 255,
// fires a one-cycle spike at a programmable threshold, and then blocks input
// for a fixed number of enabled cycles.
module neuron_lif_integrator #(
  parameter int LEAK_SHIFT     = 3,
  parameter int REFRACT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_sum,
  output logic       in_ready,
  input  logic [7:0] threshold,
  output logic       spike,
  output logic [7:0] membrane,
  output logic [7:0] spike_count
);

  typedef enum logic {
    INTEGRATE  = 1'b0,
    REFRACTORY = 1'b1
  } state_t;

  localparam logic [3:0] RC_INIT = 4'(REFRACT_CYCLES);

  state_t     state_reg, state_next;
  logic [7:0] v_reg, v_next;
  logic       spike_reg, spike_next;
  logic [7:0] count_reg, count_next;
  logic [3:0] rc_reg, rc_next;

  logic [7:0] leak_shifted;
  logic [7:0] leak;
  logic [7:0] lv;
  logic [8:0] t_sum;
  logic [7:0] vn;
  logic       transfer;
  logic       fire;

  assign in_ready = ena && (state_reg == INTEGRATE);
  assign transfer = in_valid && in_ready;

  // Leak, integrate and saturate: candidate membrane value for an integrate cycle.
  // A non-zero membrane always loses at least 1 so it decays all the way to 0.
  always_comb begin
    leak_shifted = v_reg >> LEAK_SHIFT;
    leak         = leak_shifted;
    if (leak_shifted == 8'd0 && v_reg != 8'd0) begin
      leak = 8'd1;
    end
    lv    = v_reg - leak;
    t_sum = {1'b0, lv} + {1'b0, (transfer ? in_sum : 8'd0)};
    vn    = t_sum[8] ? 8'hFF : t_sum[7:0];
    fire  = (threshold != 8'd0) && (vn >= threshold);
  end

  // Next-state and next-output logic; the spike pulse defaults low every edge.
  always_comb begin
    state_next = state_reg;
    v_next     = v_reg;
    spike_next = 1'b0;
    count_next = count_reg;
    rc_next    = rc_reg;
    if (ena) begin
      case (state_reg)
        INTEGRATE: begin
          if (fire) begin
            v_next     = 8'd0;
            spike_next = 1'b1;
            count_next = count_reg + 8'd1;
            rc_next    = RC_INIT;
            state_next = REFRACTORY;
          end else begin
            v_next = vn;
          end
        end
        REFRACTORY: begin
          v_next  = 8'd0;
          rc_next = rc_reg - 4'd1;
          if (rc_reg == 4'd1) begin
            state_next = INTEGRATE;
          end
        end
        default: begin
          state_next = INTEGRATE;
        end
      endcase
    end
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INTEGRATE;
      v_reg     <= 8'd0;
      spike_reg <= 1'b0;
      count_reg <= 8'd0;
      rc_reg    <= 4'd0;
    end else begin
      state_reg <= state_next;
      v_reg     <= v_next;
      spike_reg <= spike_next;
      count_reg <= count_next;
      rc_reg    <= rc_next;
    end
  end

  assign spike       = spike_reg;
  assign membrane    = v_reg;
  assign spike_count = count_reg;

endmodule
